// File: rtl/sha512_msg_sched.sv
// SHA-512 message schedule: loads a 16-word block, then streams W[0..ROUNDS-1].
// Optional SCHED_PREFETCH_EN adds a second buffer so the next block can load during RUN.
module sha512_msg_sched #(
  parameter int ROUNDS = 80
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        enable,
  output logic        w_valid,
  output logic [63:0] w_data,
  output logic [6:0]  w_round,
  output logic        w_last
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic [6:0]  rcnt_q, rcnt_d;
  logic [63:0] win_q [16];
  logic [63:0] win_d [16];
  logic        w_valid_q, w_valid_d;
  logic [63:0] w_data_q, w_data_d;
  logic [6:0]  w_round_q, w_round_d;
  logic        w_last_q, w_last_d;
  logic        accept_s;
`ifdef SCHED_PREFETCH_EN
  logic [63:0] pbuf_q [16];
  logic [63:0] pbuf_d [16];
  logic [4:0]  pcnt_q, pcnt_d;
`endif

  // Next-state, window shift and registered-output computation.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    rcnt_d  = rcnt_q;
    win_d   = win_q;
`ifdef SCHED_PREFETCH_EN
    pbuf_d  = pbuf_q;
    pcnt_d  = pcnt_q;
    in_ready = reset_n && ((state_q == LOAD) || (pcnt_q != 5'd16));
`else
    in_ready = reset_n && (state_q == LOAD);
`endif
    accept_s = in_valid && in_ready;

    case (state_q)
      LOAD: begin
        if (accept_s) begin
          win_d[lcnt_q] = in_data;
          if (lcnt_q == 4'd15) begin
            state_d = RUN;
            lcnt_d  = 4'd0;
            rcnt_d  = 7'd0;
          end else begin
            lcnt_d = lcnt_q + 4'd1;
          end
        end else begin
          lcnt_d = lcnt_q;
        end
      end
      RUN: begin
`ifdef SCHED_PREFETCH_EN
        if (accept_s) begin
          pbuf_d[pcnt_q[3:0]] = in_data;
          pcnt_d = pcnt_q + 5'd1;
        end else begin
          pcnt_d = pcnt_q;
        end
`endif
        if (enable) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i + 1];
          end
          win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
          rcnt_d = rcnt_q + 7'd1;
          if (rcnt_q == LAST_ROUND) begin
            rcnt_d = 7'd0;
`ifdef SCHED_PREFETCH_EN
            // Hand the prefetched words over; a full buffer keeps RUN going with no gap.
            win_d = pbuf_d;
            if (pcnt_d == 5'd16) begin
              state_d = RUN;
              lcnt_d  = 4'd0;
            end else begin
              state_d = LOAD;
              lcnt_d  = pcnt_d[3:0];
            end
            pcnt_d = 5'd0;
`else
            state_d = LOAD;
            lcnt_d  = 4'd0;
`endif
          end else begin
            state_d = RUN;
          end
        end else begin
          rcnt_d = rcnt_q;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    if (state_d == RUN) begin
      w_valid_d = 1'b1;
      w_data_d  = win_d[0];
      w_round_d = rcnt_d;
      w_last_d  = (rcnt_d == LAST_ROUND);
    end else begin
      w_valid_d = 1'b0;
      w_data_d  = 64'd0;
      w_round_d = 7'd0;
      w_last_d  = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= LOAD;
      lcnt_q    <= 4'd0;
      rcnt_q    <= 7'd0;
      win_q     <= '{default: 64'd0};
      w_valid_q <= 1'b0;
      w_data_q  <= 64'd0;
      w_round_q <= 7'd0;
      w_last_q  <= 1'b0;
`ifdef SCHED_PREFETCH_EN
      pbuf_q    <= '{default: 64'd0};
      pcnt_q    <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      rcnt_q    <= rcnt_d;
      win_q     <= win_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      w_round_q <= w_round_d;
      w_last_q  <= w_last_d;
`ifdef SCHED_PREFETCH_EN
      pbuf_q    <= pbuf_d;
      pcnt_q    <= pcnt_d;
`endif
    end
  end

  assign w_valid = w_valid_q;
  assign w_data  = w_data_q;
  assign w_round = w_round_q;
  assign w_last  = w_last_q;

endmodule
